// File: rtl/multi_pkg.sv
// Shared definitions for the multi-cycle memory stage and its control unit.
// Holds FSM encoding, access kinds and the instruction field positions.
// No logic, so no latency or backpressure of its own.
package multi_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      LOAD  = 2'd1,
      STORE = 2'd2
   } kind_t;

   localparam int OP_HI    = 31;
   localparam int OP_LO    = 26;
   localparam int FUNCT_HI = 5;
   localparam int FUNCT_LO = 0;

   function automatic logic byte_offset_set(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction

endpackage

// File: rtl/mem_req_edge.sv
// Turns control-unit request levels into prioritised one-cycle start pulses.
// Zero latency from the rising level; previous levels registered one cycle.
// No backpressure: the consumer decides whether a pulse is accepted.
module mem_req_edge (
   input  logic clk,
   input  logic rst,
   input  logic IRWrite,
   input  logic MemWrite,
   input  logic IorD,
   output logic fetch_start,
   output logic store_start,
   output logic load_start
);

   logic st_lvl;
   logic ld_lvl;
   logic irw_q;
   logic st_q;
   logic ld_q;

   assign st_lvl = IorD & MemWrite;
   assign ld_lvl = IorD & ~MemWrite & ~IRWrite;

   always_ff @(posedge clk) begin
      if (rst) begin
         irw_q <= 1'b0;
         st_q  <= 1'b0;
         ld_q  <= 1'b0;
      end else begin
         irw_q <= IRWrite;
         st_q  <= st_lvl;
         ld_q  <= ld_lvl;
      end
   end

   // Fetch wins: a store edge while IRWrite is high is discarded outright.
   assign fetch_start = IRWrite & ~irw_q;
   assign store_start = st_lvl & ~st_q & ~IRWrite;
   assign load_start  = ld_lvl & ~ld_q;

endmodule

// File: rtl/multi_mem_stage.sv
// Memory stage: drives a synchronous RAM and captures results into IR / DR.
// Read: edge + RD_LATENCY + 1 cycles to capture, ready the cycle after; store: ready next cycle.
// No queueing: request edges while busy or in DONE are dropped.
module multi_mem_stage
   import multi_pkg::*;
#(
   parameter int ADDR_W     = 14,
   parameter int RD_LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       pc,
   input  logic [31:0]       alu_out,
   input  logic [31:0]       wd,
   input  logic              IorD,
   input  logic              MemWrite,
   input  logic              IRWrite,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_en,
   output logic              mem_we,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       instr,
   output logic [5:0]        Op,
   output logic [5:0]        Funct,
   output logic [31:0]       data,
   output logic              busy,
   output logic              ready,
   output logic              misaligned
);

   localparam logic [2:0] CNT_INIT = 3'(RD_LATENCY - 1);

   state_t      state;
   kind_t       kind;
   logic [2:0]  cnt;
   logic        fetch_start;
   logic        store_start;
   logic        load_start;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^{pc[31:ADDR_W+2], alu_out[31:ADDR_W+2]};

   mem_req_edge u_edge (
      .clk         (clk),
      .rst         (rst),
      .IRWrite     (IRWrite),
      .MemWrite    (MemWrite),
      .IorD        (IorD),
      .fetch_start (fetch_start),
      .store_start (store_start),
      .load_start  (load_start)
   );

   assign Op    = instr[OP_HI:OP_LO];
   assign Funct = instr[FUNCT_HI:FUNCT_LO];

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         kind       <= FETCH;
         cnt        <= 3'd0;
         mem_addr   <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_wdata  <= 32'd0;
         instr      <= 32'd0;
         data       <= 32'd0;
         busy       <= 1'b0;
         ready      <= 1'b0;
         misaligned <= 1'b0;
      end else begin
         mem_en <= 1'b0;
         mem_we <= 1'b0;
         ready  <= 1'b0;
         case (state)
            IDLE: begin
               if (fetch_start || load_start) begin
                  mem_en     <= 1'b1;
                  mem_addr   <= fetch_start ? pc[ADDR_W+1:2] : alu_out[ADDR_W+1:2];
                  misaligned <= byte_offset_set(fetch_start ? pc[1:0] : alu_out[1:0]);
                  kind       <= fetch_start ? FETCH : LOAD;
                  cnt        <= CNT_INIT;
                  busy       <= 1'b1;
                  state      <= WAIT;
               end else if (store_start) begin
                  mem_en     <= 1'b1;
                  mem_we     <= 1'b1;
                  mem_wdata  <= wd;
                  mem_addr   <= alu_out[ADDR_W+1:2];
                  misaligned <= byte_offset_set(alu_out[1:0]);
                  ready      <= 1'b1;
                  state      <= DONE;
               end
            end
            WAIT: begin
               if (cnt == 3'd0) begin
                  state <= CAPTURE;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            CAPTURE: begin
               if (kind == FETCH) begin
                  instr <= mem_rdata;
               end else begin
                  data <= mem_rdata;
               end
               busy  <= 1'b0;
               ready <= 1'b1;
               state <= DONE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multi_mem_stage.sv
// Bench for multi_mem_stage: RAM model, scoreboard queues for RAM accesses and completions.
module tb_multi_mem_stage;

   localparam int AW  = 14;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   pc, alu_out, wd;
   logic          IorD, MemWrite, IRWrite;
   logic [AW-1:0] mem_addr;
   logic          mem_en, mem_we;
   logic [31:0]   mem_wdata, mem_rdata;
   logic [31:0]   instr, data;
   logic [5:0]    Op, Funct;
   logic          busy, ready, misaligned;

   int tests = 0;
   int errors = 0;
   int we_cycles = 0;

   typedef struct {
      logic [AW-1:0] addr;
      logic          we;
      logic [31:0]   wdata;
   } mem_exp_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] data;
      logic        mis;
   } done_exp_t;

   mem_exp_t  mq[$];
   done_exp_t rq[$];
   mem_exp_t  m;
   done_exp_t e;

   multi_mem_stage #(.ADDR_W(AW), .RD_LATENCY(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .pc         (pc),
      .alu_out    (alu_out),
      .wd         (wd),
      .IorD       (IorD),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .mem_addr   (mem_addr),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .instr      (instr),
      .Op         (Op),
      .Funct      (Funct),
      .data       (data),
      .busy       (busy),
      .ready      (ready),
      .misaligned (misaligned)
   );

   always #5 clk = ~clk;

   // Synchronous RAM: data appears LAT rising edges after the enabled edge and holds.
   logic [31:0] ram [0:(1<<AW)-1];
   logic [31:0] pipe_d [0:LAT-1];
   logic        pipe_v [0:LAT-1];
   assign mem_rdata = pipe_d[LAT-1];

   always @(posedge clk) begin
      if (rst) begin
         ram[4] = 32'h8C43_0004;
         ram[9] = 32'h1234_5678;
      end
      for (int i = LAT - 1; i >= 1; i--) begin
         if (pipe_v[i-1]) pipe_d[i] <= pipe_d[i-1];
         pipe_v[i] <= pipe_v[i-1];
      end
      pipe_v[0] <= mem_en & ~mem_we;
      if (mem_en & ~mem_we) pipe_d[0] <= ram[mem_addr];
      if (mem_en & mem_we) ram[mem_addr] = mem_wdata;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_en === 1'b1) begin
         check_val("mem_access_expected", 32'(mq.size() != 0), 32'd1);
         if (mq.size() != 0) begin
            m = mq.pop_front();
            check_val("mem_addr", 32'(mem_addr), 32'(m.addr));
            check_val("mem_we", 32'(mem_we), 32'(m.we));
            if (m.we) check_val("mem_wdata", mem_wdata, m.wdata);
         end
      end
      if (mem_we === 1'b1) we_cycles++;
      if (ready === 1'b1) begin
         check_val("ready_expected", 32'(rq.size() != 0), 32'd1);
         if (rq.size() != 0) begin
            e = rq.pop_front();
            check_val("instr", instr, e.instr);
            check_val("op", 32'(Op), 32'(e.instr[31:26]));
            check_val("funct", 32'(Funct), 32'(e.instr[5:0]));
            check_val("data", data, e.data);
            check_val("misaligned", 32'(misaligned), 32'(e.mis));
         end
      end
   end

   // Caller raises the request levels at a negedge; this drops them after 'hold'
   // negedges, optionally raises a store at 'inj', and measures edge-to-ready.
   task automatic run_req(input string tag, input int hold, input int inj, input int exp_lat);
      int lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) check_val({tag, "_busy"}, 32'(busy), 32'(exp_lat > 1));
         if (i == inj) begin
            IorD = 1'b1;
            MemWrite = 1'b1;
         end
         if (i == hold) begin
            IRWrite = 1'b0;
            MemWrite = 1'b0;
            IorD = 1'b0;
         end
         if (ready && lat == 0) lat = i;
         if (lat != 0 && i >= hold) break;
      end
      check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      pc = 32'd0; alu_out = 32'd0; wd = 32'd0;
      IorD = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst_instr", instr, 32'd0);
      check_val("rst_op_funct", {20'd0, Op, Funct}, 32'd0);
      check_val("rst_data", data, 32'd0);
      check_val("rst_flags", {27'd0, busy, ready, misaligned, mem_en, mem_we}, 32'd0);
      check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
      check_val("rst_mem_wdata", mem_wdata, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Fetch from word 4.
      pc = 32'h10; IRWrite = 1'b1;
      mq.push_back('{addr: 14'd4, we: 1'b0, wdata: 32'd0});
      rq.push_back('{instr: 32'h8C43_0004, data: 32'd0, mis: 1'b0});
      run_req("fetch", 2, 0, LAT + 2);

      // Store held three cycles: exactly one write.
      alu_out = 32'h20; wd = 32'hDEAD_BEEF; IorD = 1'b1; MemWrite = 1'b1;
      mq.push_back('{addr: 14'd8, we: 1'b1, wdata: 32'hDEAD_BEEF});
      rq.push_back('{instr: 32'h8C43_0004, data: 32'd0, mis: 1'b0});
      run_req("store", 3, 0, 1);

      // Fetch back the stored word.
      pc = 32'h20; IRWrite = 1'b1;
      mq.push_back('{addr: 14'd8, we: 1'b0, wdata: 32'd0});
      rq.push_back('{instr: 32'hDEAD_BEEF, data: 32'd0, mis: 1'b0});
      run_req("fetch_back", 2, 0, LAT + 2);

      // Load word 9.
      alu_out = 32'h24; IorD = 1'b1; MemWrite = 1'b0;
      mq.push_back('{addr: 14'd9, we: 1'b0, wdata: 32'd0});
      rq.push_back('{instr: 32'hDEAD_BEEF, data: 32'h1234_5678, mis: 1'b0});
      run_req("load", 2, 0, LAT + 2);

      // Store edge arrives during the fetch WAIT: must be ignored.
      pc = 32'h10; alu_out = 32'h30; wd = 32'h0BAD_0BAD; IRWrite = 1'b1;
      mq.push_back('{addr: 14'd4, we: 1'b0, wdata: 32'd0});
      rq.push_back('{instr: 32'h8C43_0004, data: 32'h1234_5678, mis: 1'b0});
      run_req("collide", 3, 1, LAT + 2);

      // Misaligned load still reads word 9.
      alu_out = 32'h26; IorD = 1'b1; MemWrite = 1'b0;
      mq.push_back('{addr: 14'd9, we: 1'b0, wdata: 32'd0});
      rq.push_back('{instr: 32'h8C43_0004, data: 32'h1234_5678, mis: 1'b1});
      run_req("misalign", 2, 0, LAT + 2);
      check_val("misaligned_sticky", 32'(misaligned), 32'd1);

      // Aligned fetch clears it.
      pc = 32'h20; IRWrite = 1'b1;
      mq.push_back('{addr: 14'd8, we: 1'b0, wdata: 32'd0});
      rq.push_back('{instr: 32'hDEAD_BEEF, data: 32'h1234_5678, mis: 1'b0});
      run_req("realign", 2, 0, LAT + 2);
      check_val("misaligned_clear", 32'(misaligned), 32'd0);

      // Reset while waiting on a fetch: no capture afterwards.
      pc = 32'h10; IRWrite = 1'b1;
      mq.push_back('{addr: 14'd4, we: 1'b0, wdata: 32'd0});
      @(negedge clk);
      check_val("rstmid_busy_before", 32'(busy), 32'd1);
      rst = 1'b1; IRWrite = 1'b0;
      @(negedge clk);
      check_val("rstmid_busy", 32'(busy), 32'd0);
      check_val("rstmid_ready", 32'(ready), 32'd0);
      check_val("rstmid_instr", instr, 32'd0);
      check_val("rstmid_data", data, 32'd0);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check_val("rstmid_instr_after", instr, 32'd0);
      check_val("rstmid_data_after", data, 32'd0);

      check_val("we_total", 32'(we_cycles), 32'd1);
      check_val("mem_queue_drained", 32'(mq.size()), 32'd0);
      check_val("done_queue_drained", 32'(rq.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
